led_vu_meter: RTL and testbench

LED_VU_METER -- requirements
Module: led_vu_meter

---
 rtl/led_vu_meter.sv | 96 +++++++++
 tb/tb_led_vu_meter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/led_vu_meter.sv
// VU meter for a 16-LED bar: tracks the sample magnitude with instant attack and
// linear decay, plus a peak dot that holds for a while before it falls.
module led_vu_meter #(
    parameter int DECAY_DIV  = 48000,
    parameter int DECAY_STEP = 256,
    parameter int HOLD_TICKS = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] ledbits,
    output logic [4:0]  peak_pos
);

    localparam int CW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DECAY_DIV - 1);
    localparam logic [14:0]   STEP    = (DECAY_STEP > 32767) ? 15'h7FFF : 15'(DECAY_STEP);
    localparam logic [HW-1:0] HOLD    = HW'(HOLD_TICKS);

    typedef enum logic {HOLDING, FALLING} peak_state_t;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [15:0]   absVal;
    logic [14:0]   mag;
    logic [14:0]   lvl, lvlNext;
    logic [4:0]    nNow, nReg;
    logic [4:0]    peak, peakNext;
    logic [HW-1:0] hc, hcNext;
    logic [15:0]   ledNext;
    peak_state_t   state;

    assign tick = (cnt == CNT_MAX);

    // Two's-complement negation of 0x8000 stays 0x8000, so bit 15 flags the saturating case.
    always_comb begin
        absVal = sample_in[15] ? (~sample_in + 16'd1) : sample_in;
        mag    = absVal[15] ? 15'h7FFF : absVal[14:0];
    end

    always_comb begin
        lvlNext = lvl;
        if (sample_valid && (mag > lvl))
            lvlNext = mag;
        else if (tick)
            lvlNext = (lvl > STEP) ? (lvl - STEP) : 15'd0;
    end

    assign nNow  = (lvl == 15'd0) ? 5'd0 : ({1'b0, lvl[14:11]} + 5'd1);
    assign state = (hc != '0) ? HOLDING : FALLING;

    // A rising bar always re-arms the hold; otherwise the dot only moves on ticks.
    always_comb begin
        peakNext = peak;
        hcNext   = hc;
        if (nNow > peak) begin
            peakNext = nNow;
            hcNext   = HOLD;
        end else if (tick) begin
            case (state)
                HOLDING: hcNext = hc - HW'(1);
                FALLING: if (peak > nNow) peakNext = peak - 5'd1;
                default: hcNext = hc;
            endcase
        end
    end

    always_comb begin
        ledNext = '0;
        for (int i = 0; i < 16; i++)
            ledNext[i] = (5'(i) < nReg) || ((peak != 5'd0) && (5'(i) == peak - 5'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            lvl      <= '0;
            nReg     <= '0;
            peak     <= '0;
            hc       <= '0;
            ledbits  <= '0;
            peak_pos <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + CW'(1);
            lvl      <= lvlNext;
            nReg     <= nNow;
            peak     <= peakNext;
            hc       <= hcNext;
            ledbits  <= ledNext;
            peak_pos <= peak;
        end
    end

endmodule

// File: tb/tb_led_vu_meter.sv
// Directed bench for led_vu_meter: expected LED patterns are queued with the cycle
// they are due and compared when that cycle's outputs are visible.
module tb_led_vu_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic [15:0] ledbits;
    logic [4:0]  peak_pos;

    always #5 clk = ~clk;

    led_vu_meter #(
        .DECAY_DIV(4),
        .DECAY_STEP(2048),
        .HOLD_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .ledbits(ledbits),
        .peak_pos(peak_pos)
    );

    typedef struct {
        int          due;
        logic [15:0] led;
        logic [4:0]  pp;
        string       tag;
    } exp_t;

    exp_t expQ[$];
    int   edgeCnt = 0;
    int   base    = 0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic markBase();
        base = edgeCnt;
    endtask

    task automatic expectAt(input int offset, input logic [15:0] led, input logic [4:0] pp, input string tag);
        exp_t e;
        e.due = base + offset;
        e.led = led;
        e.pp  = pp;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        while (expQ.size() > 0 && expQ[0].due <= edgeCnt) begin
            e = expQ.pop_front();
            checks++;
            assert (ledbits === e.led) else begin
                errors++;
                $error("[TB] FAIL %s ledbits observed=%h expected=%h", e.tag, ledbits, e.led);
            end
            checks++;
            assert (peak_pos === e.pp) else begin
                errors++;
                $error("[TB] FAIL %s peak_pos observed=%0d expected=%0d", e.tag, peak_pos, e.pp);
            end
        end
    endtask

    // One clock: drive inputs, take the edge, then compare whatever has come due.
    task automatic applyStimulus(input logic v, input logic [15:0] s, input logic r);
        sample_valid = v;
        sample_in    = s;
        rst          = r;
        @(posedge clk);
        #1;
        edgeCnt++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        markBase();
    endtask

    initial begin
        // Reset state, then a half-scale sample decaying to silence with peak hold and fall.
        markBase();
        expectAt(1, 16'h0000, 5'd0, "reset");
        doReset();
        expectAt(3,  16'h01FF, 5'd9, "half_scale");
        expectAt(11, 16'h017F, 5'd9, "peak_hold");
        expectAt(14, 16'h00BF, 5'd8, "peak_fall1");
        expectAt(30, 16'h000B, 5'd4, "peak_above_bar");
        expectAt(34, 16'h0004, 5'd3, "bar_empty");
        expectAt(47, 16'h0000, 5'd0, "all_idle");
        applyStimulus(1'b1, 16'h4000, 1'b0);
        idle(46);

        // Most negative sample saturates to full scale.
        doReset();
        expectAt(3, 16'hFFFF, 5'd16, "neg_full");
        expectAt(6, 16'hFFFF, 5'd16, "neg_full_decay");
        applyStimulus(1'b1, 16'h8000, 1'b0);
        idle(5);

        doReset();
        expectAt(3, 16'h01FF, 5'd9, "neg_half");
        applyStimulus(1'b1, 16'hC000, 1'b0);
        idle(2);

        // Attack lands in the same cycle as a decay tick.
        doReset();
        expectAt(3, 16'h0003, 5'd2, "pre_tick");
        expectAt(6, 16'h0007, 5'd3, "attack_on_tick");
        applyStimulus(1'b1, 16'h0800, 1'b0);
        idle(2);
        applyStimulus(1'b1, 16'h1000, 1'b0);
        idle(2);

        // Reset during hold, with a strobe that must be ignored, then tick phase after release.
        doReset();
        expectAt(3, 16'hFFFF, 5'd16, "max_pos");
        expectAt(5, 16'h0000, 5'd0,  "rst_mid_hold");
        applyStimulus(1'b1, 16'h7FFF, 1'b0);
        idle(3);
        applyStimulus(1'b1, 16'h7FFF, 1'b1);
        markBase();
        expectAt(3, 16'h0003, 5'd2, "post_rst_bar");
        expectAt(5, 16'h0003, 5'd2, "tick_not_early");
        expectAt(6, 16'h0002, 5'd2, "tick_on_time");
        applyStimulus(1'b1, 16'h0800, 1'b0);
        idle(5);

        // Back-to-back strobes keep the largest.
        doReset();
        expectAt(3, 16'h0001, 5'd1,  "b2b_first");
        expectAt(4, 16'h1FFF, 5'd13, "b2b_max");
        expectAt(5, 16'h1FFF, 5'd13, "b2b_retained");
        applyStimulus(1'b1, 16'h0100, 1'b0);
        applyStimulus(1'b1, 16'h6000, 1'b0);
        applyStimulus(1'b1, 16'h0200, 1'b0);
        idle(2);

        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain observed=%0d pending expected=0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
